fp_normalizer: RTL and testbench

Multi-cycle normalize-and-round stage for the FP datapath. Takes a raw sign/exponent/wide-mantissa result from the arithmetic core, normalizes it with one bit shift per cycle, rounds to nearest-even at the precision selected by `mode_fp`, and range-checks it. It emits `sign`/`exp[7:0]`/`mant[22:0]` in the internal extended format consumed directly by the IEEE-754 encoder. Half-precision results are rounded here, so the encoder's truncation of `mant[22:13]` is exact.

---
 rtl/fp_normalizer.sv | 220 ++++++++++++++++++++++
 tb/tb_fp_normalizer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - multi-cycle normalize, round-to-nearest-even and range-check stage
module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode_fp,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  input  logic [47:0] mant_in,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [22:0] mant,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  state_t state_q, state_d;

  // working mantissa carries one spare bit above the bit-47 overflow position
  logic [48:0]        m_q, m_d;
  logic signed [11:0] e_q, e_d;
  logic               stk_q, stk_d;
  logic               s_q, s_d;
  logic               mode_q, mode_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sign_q, sign_d;
  logic [7:0]         exp_q, exp_d;
  logic [22:0]        mant_q, mant_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               inex_q, inex_d;

  // rounding and range-check results, only consumed in ROUND
  logic [22:0]        frac_raw;
  logic [22:0]        frac_rnd;
  logic [23:0]        rnd_inc;
  logic               guard;
  logic               sticky;
  logic               lsb;
  logic               round_up;
  logic               carry;
  logic signed [11:0] e_rnd;
  logic signed [11:0] e_lo;
  logic signed [11:0] e_hi;

  // round the normalized mantissa at the latched precision and pick the legal exponent window
  always_comb begin
    frac_raw = 23'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    lsb      = 1'b0;
    rnd_inc  = 24'd0;
    e_lo     = 12'sd1;
    e_hi     = 12'sd254;
    if (mode_q) begin
      frac_raw = m_q[45:23];
      guard    = m_q[22];
      sticky   = (|m_q[21:0]) | stk_q;
      lsb      = m_q[23];
      rnd_inc  = 24'h000001;
      e_lo     = 12'sd1;
      e_hi     = 12'sd254;
    end else begin
      // half-precision fraction sits left-aligned so the encoder can truncate bits 22:13 exactly
      frac_raw = {m_q[45:36], 13'd0};
      guard    = m_q[35];
      sticky   = (|m_q[34:0]) | stk_q;
      lsb      = m_q[36];
      rnd_inc  = 24'h002000;
      e_lo     = 12'sd113;
      e_hi     = 12'sd142;
    end
    round_up = guard & (sticky | lsb);
    // a carry out of the fraction leaves it all-zero, which is exactly 1.0 at the next exponent
    {carry, frac_rnd} = {1'b0, frac_raw} + (round_up ? rnd_inc : 24'd0);
    e_rnd = e_q + {11'd0, carry};
  end

  // next-state, datapath and output-register updates for the IDLE/SHIFT/ROUND sequence
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    stk_d   = stk_q;
    s_d     = s_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    inex_d  = inex_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {1'b0, mant_in};
          e_d     = {{2{exp_in[9]}}, exp_in};
          stk_d   = 1'b0;
          s_d     = sign_in;
          mode_d  = mode_fp;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          inex_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (m_q == 49'd0) begin
          state_d = S_ROUND;
        end else if (m_q[47]) begin
          // the bit shifted out is folded into sticky so rounding still sees it
          m_d   = m_q >> 1;
          stk_d = stk_q | m_q[0];
          e_d   = e_q + 12'sd1;
        end else if (!m_q[46]) begin
          m_d = m_q << 1;
          e_d = e_q - 12'sd1;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        sign_d  = s_q;
        e_d     = e_rnd;
        if (m_q == 49'd0) begin
          exp_d  = 8'h00;
          mant_d = 23'd0;
          ovf_d  = 1'b0;
          udf_d  = 1'b0;
          inex_d = 1'b0;
        end else if (e_rnd > e_hi) begin
          exp_d  = 8'hFF;
          mant_d = 23'd0;
          ovf_d  = 1'b1;
          inex_d = 1'b1;
        end else if (e_rnd < e_lo) begin
          // denormals are not produced; anything below the window flushes to signed zero
          exp_d  = 8'h00;
          mant_d = 23'd0;
          udf_d  = 1'b1;
          inex_d = 1'b1;
        end else begin
          exp_d  = e_rnd[7:0];
          mant_d = frac_rnd;
          inex_d = guard | sticky;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= 49'd0;
      e_q     <= 12'sd0;
      stk_q   <= 1'b0;
      s_q     <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= 8'h00;
      mant_q  <= 23'd0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      inex_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      stk_q   <= stk_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      inex_q  <= inex_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sign      = sign_q;
  assign exp       = exp_q;
  assign mant      = mant_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign inexact   = inex_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - scoreboard bench for fp_normalizer against an arithmetic rounding model
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode_fp;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [47:0] mant_in;
  logic        busy;
  logic        done;
  logic        sign;
  logic [7:0]  exp;
  logic [22:0] mant;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  fp_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode_fp   (mode_fp),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .busy      (busy),
    .done      (done),
    .sign      (sign),
    .exp       (exp),
    .mant      (mant),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [7:0]  ex;
    logic [22:0] mn;
    bit          ov;
    bit          ud;
    bit          ix;
    int          shifts;
    int          scyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   bc     = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  // value = mant * 2^(exp-127-46); round the exact integer quotient to p fraction bits
  function automatic exp_t model(input bit md, input bit sg, input logic [9:0] ei, input logic [47:0] mi);
    exp_t r;
    int msb, p, k, e;
    logic [95:0] x, q, rem, half;
    r.sgn = sg; r.ex = 8'h00; r.mn = 23'd0; r.ov = 0; r.ud = 0; r.ix = 0; r.shifts = 0; r.scyc = 0;
    if (mi == 48'd0) return r;
    msb = 0;
    for (int i = 0; i < 48; i++) if (mi[i]) msb = i;
    r.shifts = (msb == 47) ? 1 : 46 - msb;
    p = md ? 23 : 10;
    e = $signed(ei) + msb - 46;
    x = {mi, 48'd0};
    k = msb + 48 - p;
    q = x >> k;
    rem = x - (q << k);
    half = 96'd1 << (k - 1);
    r.ix = (rem != 96'd0);
    if (rem > half || (rem == half && q[0])) q = q + 96'd1;
    if (q == (96'd1 << (p + 1))) begin
      q = 96'd1 << p;
      e = e + 1;
    end
    if (e > (md ? 254 : 142)) begin
      r.ex = 8'hFF; r.ov = 1; r.ix = 1;
    end else if (e < (md ? 1 : 113)) begin
      r.ud = 1; r.ix = 1;
    end else begin
      r.ex = e[7:0];
      r.mn = md ? q[22:0] : {q[9:0], 13'd0};
    end
    return r;
  endfunction

  task automatic issue(input bit md, input bit sg, input logic [9:0] ei, input logic [47:0] mi);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_wait", busy, 0);
    mode_fp = md; sign_in = sg; exp_in = ei; mant_in = mi; start = 1'b1;
    x = model(md, sg, ei, mi);
    x.scyc = cyc;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  // monitor: pop expectation on every done and check result, latency and busy duration
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      bc = 0;
    end else begin
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          x = sb.pop_front();
          chk("sign", sign, x.sgn);
          chk("exp", exp, x.ex);
          chk("mant", mant, x.mn);
          chk("overflow", overflow, x.ov);
          chk("underflow", underflow, x.ud);
          chk("inexact", inexact, x.ix);
          chk("latency", cyc - x.scyc, 3 + x.shifts);
          chk("busy_cycles", bc, 2 + x.shifts);
        end
        bc = 0;
      end
      if (busy) bc++;
    end
  end

  initial begin
    logic [63:0] r64;
    logic [47:0] mi;
    int msb, nd, n;
    bit md;
    logic [9:0] ei;

    rst_n = 1'b0; start = 1'b0; mode_fp = 1'b0; sign_in = 1'b0; exp_in = 10'd0; mant_in = 48'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sign", sign, 0);
    chk("rst_exp", exp, 0);
    chk("rst_mant", mant, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_inex", inexact, 0);
    rst_n = 1'b1;

    issue(1, 0, 10'd127, 48'd1 << 46);
    issue(1, 0, 10'd127, 48'd3 << 46);
    issue(0, 0, 10'd127, (48'd1 << 46) | (48'd1 << 35));
    issue(0, 1, 10'd127, (48'd1 << 46) | (48'd1 << 36) | (48'd1 << 35));
    issue(1, 0, 10'd127, 48'd1 << 40);
    // start while busy must be dropped
    mode_fp = 1'b0; sign_in = 1'b1; exp_in = 10'd3; mant_in = 48'hFFFF_FFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(0, 0, 10'd143, 48'd1 << 46);
    issue(1, 0, 10'd0, 48'd1 << 46);
    issue(1, 1, 10'd200, 48'd0);
    issue(1, 0, 10'd127, 48'h7FFF_FFFF_FFFF);
    issue(0, 1, 10'd142, 48'h7FFF_FFFF_FFFF);
    issue(1, 0, 10'h3FB, 48'd1 << 46);
    issue(1, 1, 10'd254, 48'hFFFF_FFFF_FFFF);

    // abort a long left normalization with reset
    issue(1, 0, 10'd127, 48'd1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_exp", exp, 0);
    chk("abort_mant", mant, 0);
    chk("abort_sign", sign, 0);
    chk("abort_flags", {overflow, underflow, inexact}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = n_done;
    repeat (60) @(negedge clk);
    chk("no_done_after_abort", n_done, nd);
    issue(1, 0, 10'd127, 48'd1 << 46);

    for (int t = 0; t < 150; t++) begin
      md = 1'($urandom_range(0, 1));
      msb = $urandom_range(0, 47);
      r64 = {$urandom(), $urandom()};
      mi = r64[47:0];
      mi = (mi & ((48'd1 << (msb + 1)) - 48'd1)) | (48'd1 << msb);
      if ($urandom_range(0, 15) == 0) mi = 48'd0;
      if ($urandom_range(0, 3) == 0) ei = 10'($urandom_range(0, 1023));
      else if (md) ei = 10'($urandom_range(0, 300));
      else ei = 10'($urandom_range(105, 190));
      issue(md, 1'($urandom_range(0, 1)), ei, mi);
    end

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
